// File: rtl/uart_apb_master_if.sv
// rtl/uart_apb_master_if.sv - command/response stream and APB3 bus bundle for uart_apb_master
interface uart_apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB3 bus
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // initiator side: accepts commands, returns responses, drives the APB bus
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // environment side: command source, response sink and APB slave
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - APB3 initiator turning a valid/ready command stream into single transfers
module uart_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  uart_apb_master_if.master bus
);

  // Counter only needs to reach TIMEOUT-1; the terminal count ends the transfer.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cmd_ready;
  logic accept;

  // A new command is only taken when idle and the response slot is free or being drained.
  assign cmd_ready = (state_q == IDLE) & (~rsp_valid_q | bus.rsp_ready);
  assign accept    = bus.cmd_valid & cmd_ready;

  assign bus.cmd_ready   = cmd_ready;
  assign bus.PSEL        = (state_q != IDLE);
  assign bus.PENABLE     = (state_q == ACCESS);
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Next-state logic: APB phase sequencing, wait-state counting and response capture.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over an expiring timeout in the same cycle.
        if (bus.PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the bus and discards any pending response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: doc/uart_apb_master.md
# uart_apb_master

APB3 initiator that turns a simple valid/ready command stream into single APB3 read or write transfers. It drives the UART configuration/status register slave and any other APB3 peripheral on the same bus. It supports wait states via PREADY, error reporting via PSLVERR, and a programmable PREADY timeout so a hung slave cannot stall the initiator. Typical users are a boot sequencer or a test controller that programs CLKS_PER_BIT and TDR and polls status.

## Interface
Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 256, maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready. Tie to 1 for slaves without PREADY.
- PSLVERR  in  1  slave error. Tie to 0 if unused.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - cmd_ready = (state==IDLE) & (!rsp_valid | rsp_ready). This output is combinational.
  - On accept: register cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0, timeout counter cleared. Always goes to ACCESS after exactly one cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1 sampled: complete. Load rsp_rdata with PRDATA for a read or 0 for a write. Load rsp_err with PSLVERR and rsp_timeout with 0. Set rsp_valid, go to IDLE.
  - PREADY=0 sampled: increment the counter.
  - Timeout: TIMEOUT≠0 and the counter reaches TIMEOUT-1 while PREADY=0. Complete with rsp_rdata=0, rsp_err=1, rsp_timeout=1, and go to IDLE.
  - PREADY=1 in the same cycle as the timeout condition: the PREADY completion wins.
- Counter width is $clog2(TIMEOUT+1), minimum 1. The counter never wraps because the terminal count ends the transfer.
- PADDR, PWRITE and PWDATA stay stable from SETUP to the end of ACCESS. Between transfers they keep their last value.
- Response register:
  - Single entry. rsp_valid is cleared on rsp_valid & rsp_ready.
  - A new completion cannot occur while rsp_valid=1, because cmd_ready blocks new commands.
- Only one outstanding transfer. No pipelining across APB phases.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, state=IDLE.
- Cycle numbering from the accept edge at cycle 0:
  - cycle 1 is SETUP;
  - cycle 2 is the first ACCESS cycle;
  - with no wait states, rsp_valid=1 in cycle 3.
  - With N wait states, rsp_valid=1 in cycle 3+N.
- Back-to-back throughput:
  - If rsp_ready=1 and cmd_valid=1 in the rsp_valid cycle, the next command is accepted in that same cycle.
  - The minimum period is 3 cycles per transfer.
- rsp_ready held low: rsp_valid and the response fields stay frozen, cmd_ready=0, and the bus stays idle.
- Reset asserted mid-transfer:
  - PSEL and PENABLE drop asynchronously and the FSM returns to IDLE.
  - Any pending response is discarded and no response is generated.
  - The first accept after deassertion is allowed on the first PCLK edge with PRESETn=1.
- PRDATA and PSLVERR are sampled only on the completing ACCESS edge.

## Test plan
- Write with PREADY=1, addr 0xC, wdata 0xD9:
  - PSEL=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2 with PWRITE=1, PADDR=0xC, PWDATA=0xD9;
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read addr 0x0 with the slave returning PRDATA=0x000000FF: rsp_rdata=0xFF, rsp_err=0, rsp_valid in cycle 3.
- Read with PREADY low for 3 ACCESS cycles:
  - ACCESS lasts 4 cycles and PADDR stays stable;
  - rsp_valid in cycle 6 with the data sampled on the PREADY=1 edge.
- Write with PSLVERR=1 on the PREADY cycle: rsp_err=1, rsp_timeout=0.
- TIMEOUT=16 with PREADY stuck at 0:
  - PENABLE is high for exactly 16 cycles, then PSEL=0;
  - response has rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 on the 16th cycle: normal completion, rsp_timeout=0.
- Backpressure and reset:
  - rsp_ready=0 for 10 cycles with cmd_valid=1: cmd_ready=0 and PSEL=0 throughout, response fields unchanged.
  - PRESETn pulsed low during ACCESS: PSEL=0 immediately, no rsp_valid, and the next command completes normally.
